// File: rtl/fan_pid_pkg.sv
// Shared state encoding, term ordering and sizing helpers for the multi-channel fan PID core.
package fan_pid_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MAC  = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Order in which the five difference-equation terms pass through the MAC.
   localparam logic [2:0] T_B2 = 3'd0;
   localparam logic [2:0] T_B1 = 3'd1;
   localparam logic [2:0] T_B0 = 3'd2;
   localparam logic [2:0] T_A1 = 3'd3;
   localparam logic [2:0] T_A0 = 3'd4;

   function automatic int calc_acc_w(input int adc_w, input int frac_w);
      return adc_w + 2 * frac_w + 5;
   endfunction

   function automatic longint sat_max(input int adc_w, input int frac_w);
      return (longint'(1) <<< (adc_w + 2 * frac_w)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int adc_w, input int frac_w);
      return -(longint'(1) <<< (adc_w + 2 * frac_w));
   endfunction

endpackage

// File: rtl/fan_pid_mac.sv
// Shared signed multiply-accumulate unit: one coefficient x operand product per enabled cycle.
module fan_pid_mac
   import fan_pid_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int ACC_W = 21
) (
   input  logic                    clk_i,
   input  logic                    i_clr,
   input  logic                    i_en,
   input  logic signed [REG_W-1:0] i_coef,
   input  logic signed [ACC_W-1:0] i_data,
   output logic signed [ACC_W-1:0] o_acc
);

   logic signed [ACC_W-1:0] w_coef_x;
   logic signed [ACC_W-1:0] w_prod;
   logic signed [ACC_W-1:0] r_acc;

   assign w_coef_x = ACC_W'(i_coef);
   assign w_prod   = w_coef_x * i_data;

   // Accumulator is pure datapath; the sequencer clears it before every channel.
   always_ff @(posedge clk_i) begin
      if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_prod;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/fan_pid_mc_core.sv
// Time-multiplexed PID core: CHANNELS independent second-order loops sharing one MAC.
module fan_pid_mc_core
   import fan_pid_pkg::*;
#(
   parameter int ADC_BITWIDTH  = 8,
   parameter int REG_BITWIDTH  = 5,
   parameter int FRAC_BITWIDTH = 4,
   parameter int CHANNELS      = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_i,
   input  logic                                 clk_en_PID_i,
   input  logic [CHANNELS-1:0]                  ch_en_i,
   input  logic [CHANNELS*ADC_BITWIDTH-1:0]     ADC_value_i,
   input  logic [CHANNELS*ADC_BITWIDTH-1:0]     SET_value_i,
   input  logic signed [REG_BITWIDTH-1:0]       a1_reg_i,
   input  logic signed [REG_BITWIDTH-1:0]       a0_reg_i,
   input  logic signed [REG_BITWIDTH-1:0]       b0_reg_i,
   input  logic signed [REG_BITWIDTH-1:0]       b1_reg_i,
   input  logic signed [REG_BITWIDTH-1:0]       b2_reg_i,
   output logic [CHANNELS*(ADC_BITWIDTH+1)-1:0] out_Val_o,
   output logic [CHANNELS-1:0]                  sat_o,
   output logic                                 busy_o,
   output logic                                 done_o
);

   localparam int ACC_W = calc_acc_w(ADC_BITWIDTH, FRAC_BITWIDTH);
   localparam int OUT_W = ADC_BITWIDTH + 1;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ADC_BITWIDTH, FRAC_BITWIDTH));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ADC_BITWIDTH, FRAC_BITWIDTH));

   state_t                           r_state;
   logic [2:0]                       r_k;
   logic [CH_W-1:0]                  r_ch;
   logic [CHANNELS-1:0]              r_pend;
   logic [CHANNELS*ADC_BITWIDTH-1:0] r_adc, r_set;
   logic signed [REG_BITWIDTH-1:0]   r_a1, r_a0, r_b0, r_b1, r_b2;
   logic signed [ACC_W-1:0]          r_e;
   logic signed [ACC_W-1:0]          r_e1 [CHANNELS];
   logic signed [ACC_W-1:0]          r_e2 [CHANNELS];
   logic signed [ACC_W-1:0]          r_y1 [CHANNELS];
   logic signed [ACC_W-1:0]          r_y2 [CHANNELS];
   logic [CHANNELS-1:0]              r_sat;

   logic [CH_W-1:0]                  w_next_ch;
   logic [ADC_BITWIDTH-1:0]          w_set, w_adc;
   logic signed [ACC_W-1:0]          w_set_x, w_adc_x, w_err;
   logic signed [REG_BITWIDTH-1:0]   w_coef;
   logic signed [ACC_W-1:0]          w_data;
   logic signed [ACC_W-1:0]          w_acc;

   function automatic logic signed [ACC_W-1:0] clamp_y(input logic signed [ACC_W-1:0] y);
      if (y >= SAT_MAX) return SAT_MAX;
      if (y <= SAT_MIN) return SAT_MIN;
      return y;
   endfunction

   function automatic logic is_sat(input logic signed [ACC_W-1:0] y);
      return (y >= SAT_MAX) || (y <= SAT_MIN);
   endfunction

   // Lowest still-pending channel; disabled channels never enter r_pend, so they cost no cycles.
   always_comb begin
      w_next_ch = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (r_pend[c]) w_next_ch = CH_W'(c);
      end
   end

   assign w_set   = r_set[int'(w_next_ch) * ADC_BITWIDTH +: ADC_BITWIDTH];
   assign w_adc   = r_adc[int'(w_next_ch) * ADC_BITWIDTH +: ADC_BITWIDTH];
   assign w_set_x = ACC_W'(w_set);
   assign w_adc_x = ACC_W'(w_adc);
   assign w_err   = (w_set_x - w_adc_x) <<< FRAC_BITWIDTH;

   // Feedback terms are negated on the operand side so the coefficient never has to be.
   always_comb begin
      w_coef = '0;
      w_data = '0;
      case (r_k)
         T_B2: begin w_coef = r_b2; w_data = r_e;                                 end
         T_B1: begin w_coef = r_b1; w_data = r_e1[r_ch];                          end
         T_B0: begin w_coef = r_b0; w_data = r_e2[r_ch];                          end
         T_A1: begin w_coef = r_a1; w_data = -(r_y1[r_ch] >>> FRAC_BITWIDTH);     end
         T_A0: begin w_coef = r_a0; w_data = -(r_y2[r_ch] >>> FRAC_BITWIDTH);     end
         default: begin w_coef = '0; w_data = '0;                                 end
      endcase
   end

   fan_pid_mac #(
      .REG_W (REG_BITWIDTH),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk_i  (clk_i),
      .i_clr  (r_state == S_LOAD),
      .i_en   (r_state == S_MAC),
      .i_coef (w_coef),
      .i_data (w_data),
      .o_acc  (w_acc)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_ch    <= '0;
         r_pend  <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (clk_en_PID_i) begin
               r_pend  <= ch_en_i;
               r_state <= (ch_en_i != '0) ? S_LOAD : S_DONE;
            end
            S_LOAD: begin
               r_ch              <= w_next_ch;
               r_pend[w_next_ch] <= 1'b0;
               r_k               <= T_B2;
               r_state           <= S_MAC;
            end
            S_MAC: begin
               if (r_k == T_A0) r_state <= S_WB;
               else             r_k     <= r_k + 3'd1;
            end
            S_WB:    r_state <= (r_pend != '0) ? S_LOAD : S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (r_state == S_IDLE && clk_en_PID_i) begin
         r_adc <= ADC_value_i;
         r_set <= SET_value_i;
         r_a1  <= a1_reg_i;
         r_a0  <= a0_reg_i;
         r_b0  <= b0_reg_i;
         r_b1  <= b1_reg_i;
         r_b2  <= b2_reg_i;
      end
      if (r_state == S_LOAD) r_e <= w_err;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_e1[c] <= '0;
            r_e2[c] <= '0;
            r_y1[c] <= '0;
            r_y2[c] <= '0;
         end
         r_sat <= '0;
      end else if (r_state == S_WB) begin
         r_e1[r_ch]  <= r_e;
         r_e2[r_ch]  <= r_e1[r_ch];
         r_y1[r_ch]  <= clamp_y(w_acc);
         r_y2[r_ch]  <= r_y1[r_ch];
         r_sat[r_ch] <= is_sat(w_acc);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign out_Val_o[g*OUT_W +: OUT_W] = r_y1[g][2*FRAC_BITWIDTH +: OUT_W];
   end

   assign sat_o  = r_sat;
   assign busy_o = (r_state == S_LOAD) || (r_state == S_MAC) || (r_state == S_WB);
   assign done_o = (r_state == S_DONE);

endmodule

// File: doc/fan_pid_mc_core.md
# fan_pid_mc_core

Multi-channel, time-multiplexed successor to the single-channel fan PID core. It runs the same second-order IIR/PID difference equation for `CHANNELS` independent fan loops. All loops share one multiplier-accumulator, and each loop keeps its own error and output history. A conversion round is started by the PID tick. The block reports `busy_o`, then a `done_o` pulse. It adds per-channel enable masking and saturation flags.

## Interface
- `ADC_BITWIDTH`, 8, width of each ADC/setpoint sample.
- `REG_BITWIDTH`, 5, signed coefficient width.
- `FRAC_BITWIDTH`, 4, fractional scaling shift.
- `CHANNELS`, 2, number of independent loops (≥1).
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  reset. Asynchronous, active-low.
- `clk_en_PID_i`  in  1  start request. Accepted only when idle.
- `ch_en_i`  in  CHANNELS  per-channel enable mask. Sampled at start.
- `ADC_value_i`  in  CHANNELS·ADC_BITWIDTH  flattened measured values. Channel c is at bits `[c·ADC+:ADC]`.
- `SET_value_i`  in  CHANNELS·ADC_BITWIDTH  flattened setpoints, same packing.
- `a1_reg_i`, `a0_reg_i`, `b0_reg_i`, `b1_reg_i`, `b2_reg_i`  in  REG_BITWIDTH each  signed coefficients, shared by all channels.
- `out_Val_o`  out  CHANNELS·(ADC_BITWIDTH+1)  flattened signed outputs.
- `sat_o`  out  CHANNELS  1 when that channel's last result was clamped.
- `busy_o`  out  1  round in progress.
- `done_o`  out  1  one-cycle pulse at end of round.

## Operation
- Accumulator width: `ACC_W = ADC_BITWIDTH + 2·FRAC_BITWIDTH + 5`, signed.
- Error: `e = ({0,SET} − {0,ADC}) << FRAC_BITWIDTH`, at ACC_W.
- Result: `y = b2·e[n] + b1·e[n−1] + b0·e[n−2] − a1·(y[n−1]>>>F) − a0·(y[n−2]>>>F)`.
  - All products are signed and at ACC_W.
  - The shift `>>>` is arithmetic.
- Clamping:
  - `MAX = 2^(ADC+2F) − 1` and `MIN = −2^(ADC+2F)`.
  - If `y ≥ MAX`, the stored value is MAX. If `y ≤ MIN`, it is MIN. Both set `sat_o[c]`. Otherwise `y` is stored and `sat_o[c]` is cleared.
- Output: `out_Val_o[c] = y_c[n][ADC+2F : 2F]`.
- Snapshot at the accepted start edge: all ADC/SET values, coefficients and `ch_en_i` are copied into internal registers. Inputs may change freely while busy.
- FSM states:
  - IDLE: wait for start.
  - LOAD: select the next enabled channel, compute `e`, clear the accumulator.
  - MAC: 5 cycles, term index k = 0..4, one product per cycle.
  - WB: clamp the result, shift the channel's e/y history, update `out_Val_o[c]` and `sat_o[c]`.
  - DONE: pulse `done_o`.
- Transitions:
  - IDLE → LOAD on start with a non-zero mask; IDLE → DONE on start with mask = 0.
  - LOAD → MAC. MAC → WB after k = 4.
  - WB → LOAD if another enabled channel remains, otherwise WB → DONE.
  - DONE → IDLE.
- Channels are processed in ascending index order.
- Disabled channels are skipped with zero cycles. Their history, output and `sat_o` are held.
- A start while busy (any state except IDLE) is ignored and is not queued.

## Timing
- Reset values:
  - All history registers, `out_Val_o`, `sat_o`, `busy_o` and `done_o` are 0.
  - FSM returns to IDLE.
  - Reset asserted mid-round aborts the round immediately. No partial writeback survives.
- Start sampled at edge E0. `busy_o` is high from E0 onward.
- The j-th enabled channel (j = 1..) takes 7 cycles: LOAD, MAC×5, WB. Its output changes at edge E0 + 7j.
- With m enabled channels, DONE occupies the cycle after E0 + 7m:
  - `done_o` = 1 and `busy_o` = 0 during that cycle.
  - A start in that cycle is not accepted. The next start is accepted one cycle later, in IDLE.
- With m = 0: `done_o` is high in the cycle after E0 and no outputs change.
- Outputs are registered and stable between writebacks.

## Structure
- Package `fan_pid_pkg`:
  - FSM state enum.
  - ACC_W computation.
  - MAX/MIN constant functions.
  - Term-index constants (B2, B1, B0, A1, A0).
- Sub-module `fan_pid_mac`: one signed REG_BITWIDTH × ACC_W multiplier feeding an ACC_W accumulator, with clear and enable. It is instantiated once.
- Per-channel history is held in register arrays indexed by channel. There are no per-channel multipliers.

## Test plan
- Reset: hold `rstn_i` = 0 → all outputs 0, `busy_o` = 0. Release, idle 10 cycles → nothing changes.
- Proportional: CHANNELS = 2, b2 = 8, others 0, ch0 SET = 100 / ADC = 60, mask = 01 → `out_Val_o[0]` = 20 at E0+7, `done_o` in the cycle after E0+7, ch1 output stays 0.
- Integrator:
  - b2 = 8, a1 = −1, same inputs, two rounds → ch0 output 20 after round 1, then 21 (y = 5440).
  - A start pulsed mid-round is ignored.
- Saturation, positive: b2 = 15, a1 = −15, SET = 255 / ADC = 0 → round 1 output 239 with `sat_o` = 0; round 2 output 255 with `sat_o` = 1.
- Saturation, negative: same coefficients, SET = 0 / ADC = 255 → round 2 output −256 with `sat_o` = 1.
- Multi-channel: mask = 11, ch0 error 40, ch1 error −40, b2 = 8 → ch0 = 20 at E0+7, ch1 = −20 at E0+14, `done_o` in the cycle after E0+14, history independent across channels.
- Abort: assert `rstn_i` low during MAC of ch1 → all outputs 0 immediately. The next round after release starts from zero history.
